// File: rtl/ccu_group_rd_mux.sv
// ccu_group_rd_mux
// Read-request multiplexer for one CCU slave group. AR requests from NoSlvPerGroup
// slave ports are round-robin arbitrated onto a single master AR port. The winning
// port index is prepended to the slave ID. R beats are steered back to the owning
// port by those ID MSBs. Per-port outstanding reads are tracked and bounded.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   slv_ar_*                N slave AR channels (payload port p at slice p)
//   mst_ar_*                master AR channel, id = {port index, slave id}
//   mst_r_*                 master R channel
//   slv_r_*                 N slave R channels (payload broadcast, valid one-hot)
//   idle_o                  no outstanding reads and no AR held
//   route_err_o             sticky: an R beat carried an out-of-range port index
module ccu_group_rd_mux #(
   parameter int unsigned NoSlvPerGroup = 4,
   parameter int unsigned AxiSlvIdWidth = 4,
   parameter int unsigned AxiAddrWidth  = 64,
   parameter int unsigned AxiDataWidth  = 64,
   parameter int unsigned AxiUserWidth  = 1,
   parameter int unsigned MaxTrans      = 8
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   // slave AR
   input  logic [NoSlvPerGroup-1:0]                slv_ar_valid_i,
   output logic [NoSlvPerGroup-1:0]                slv_ar_ready_o,
   input  logic [NoSlvPerGroup*AxiSlvIdWidth-1:0]  slv_ar_id_i,
   input  logic [NoSlvPerGroup*AxiAddrWidth-1:0]   slv_ar_addr_i,
   input  logic [NoSlvPerGroup*8-1:0]              slv_ar_len_i,
   input  logic [NoSlvPerGroup*AxiUserWidth-1:0]   slv_ar_user_i,
   // master AR
   output logic                                    mst_ar_valid_o,
   input  logic                                    mst_ar_ready_i,
   output logic [AxiSlvIdWidth+$clog2(NoSlvPerGroup)-1:0] mst_ar_id_o,
   output logic [AxiAddrWidth-1:0]                 mst_ar_addr_o,
   output logic [7:0]                              mst_ar_len_o,
   output logic [AxiUserWidth-1:0]                 mst_ar_user_o,
   // master R
   input  logic                                    mst_r_valid_i,
   output logic                                    mst_r_ready_o,
   input  logic [AxiSlvIdWidth+$clog2(NoSlvPerGroup)-1:0] mst_r_id_i,
   input  logic [AxiDataWidth-1:0]                 mst_r_data_i,
   input  logic [1:0]                              mst_r_resp_i,
   input  logic                                    mst_r_last_i,
   input  logic [AxiUserWidth-1:0]                 mst_r_user_i,
   // slave R
   output logic [NoSlvPerGroup-1:0]                slv_r_valid_o,
   input  logic [NoSlvPerGroup-1:0]                slv_r_ready_i,
   output logic [NoSlvPerGroup*AxiSlvIdWidth-1:0]  slv_r_id_o,
   output logic [NoSlvPerGroup*AxiDataWidth-1:0]   slv_r_data_o,
   output logic [NoSlvPerGroup*2-1:0]              slv_r_resp_o,
   output logic [NoSlvPerGroup-1:0]                slv_r_last_o,
   output logic [NoSlvPerGroup*AxiUserWidth-1:0]   slv_r_user_o,
   // status
   output logic                                    idle_o,
   output logic                                    route_err_o
);

   localparam int unsigned IdxW = $clog2(NoSlvPerGroup);
   localparam int unsigned MIW  = AxiSlvIdWidth + IdxW;
   localparam int unsigned CntW = $clog2(MaxTrans + 1);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

   state_e                   state_q;
   logic [IdxW-1:0]          rr_ptr_q;
   logic [IdxW-1:0]          lock_idx_q;
   logic [CntW-1:0]          cnt_q [NoSlvPerGroup];

   logic [NoSlvPerGroup-1:0] eligible;
   logic [IdxW-1:0]          arb_idx;
   logic                     arb_found;
   logic [IdxW-1:0]          grant;
   logic                     ar_valid;
   logic                     ar_hs;
   logic [IdxW-1:0]          r_idx;
   logic                     r_in_range;
   logic                     r_last_hs;
   logic                     cnt_all_zero;

   // A port competes only while it has room for another outstanding read
   always_comb begin
      eligible = '0;
      for (int p = 0; p < int'(NoSlvPerGroup); p++) begin
         eligible[p] = slv_ar_valid_i[p] && (cnt_q[p] < CntW'(MaxTrans));
      end
   end

   // Round-robin search; descending loop so the smallest offset from the pointer wins
   always_comb begin
      arb_idx   = rr_ptr_q;
      arb_found = 1'b0;
      for (int i = int'(NoSlvPerGroup) - 1; i >= 0; i--) begin
         if (eligible[IdxW'((int'(rr_ptr_q) + i) % int'(NoSlvPerGroup))]) begin
            arb_idx   = IdxW'((int'(rr_ptr_q) + i) % int'(NoSlvPerGroup));
            arb_found = 1'b1;
         end
      end
   end

   // AR path: a held grant is never re-arbitrated
   assign grant          = (state_q == ST_LOCKED) ? lock_idx_q : arb_idx;
   assign ar_valid       = !rst_i && ((state_q == ST_LOCKED) || arb_found);
   assign ar_hs          = ar_valid && mst_ar_ready_i;
   assign mst_ar_valid_o = ar_valid;
   assign slv_ar_ready_o = ar_hs ? (NoSlvPerGroup'(1) << grant) : '0;
   assign mst_ar_id_o    = {grant, slv_ar_id_i[int'(grant)*int'(AxiSlvIdWidth) +: AxiSlvIdWidth]};
   assign mst_ar_addr_o  = slv_ar_addr_i[int'(grant)*int'(AxiAddrWidth) +: AxiAddrWidth];
   assign mst_ar_len_o   = slv_ar_len_i[int'(grant)*8 +: 8];
   assign mst_ar_user_o  = slv_ar_user_i[int'(grant)*int'(AxiUserWidth) +: AxiUserWidth];

   // R path: steer by ID MSBs, drop beats whose index has no port
   assign r_idx         = mst_r_id_i[MIW-1:AxiSlvIdWidth];
   assign r_in_range    = ({1'b0, r_idx} < (IdxW+1)'(NoSlvPerGroup));
   assign slv_r_valid_o = (!rst_i && mst_r_valid_i && r_in_range) ?
                          (NoSlvPerGroup'(1) << r_idx) : '0;
   assign mst_r_ready_o = !rst_i && (r_in_range ? slv_r_ready_i[r_idx] : 1'b1);
   assign r_last_hs     = mst_r_valid_i && mst_r_ready_o && r_in_range && mst_r_last_i;
   assign slv_r_id_o    = {NoSlvPerGroup{mst_r_id_i[AxiSlvIdWidth-1:0]}};
   assign slv_r_data_o  = {NoSlvPerGroup{mst_r_data_i}};
   assign slv_r_resp_o  = {NoSlvPerGroup{mst_r_resp_i}};
   assign slv_r_last_o  = {NoSlvPerGroup{mst_r_last_i}};
   assign slv_r_user_o  = {NoSlvPerGroup{mst_r_user_i}};

   always_comb begin
      cnt_all_zero = 1'b1;
      for (int p = 0; p < int'(NoSlvPerGroup); p++) begin
         if (cnt_q[p] != '0) cnt_all_zero = 1'b0;
      end
   end

   assign idle_o = rst_i || ((state_q == ST_IDLE) && cnt_all_zero);

   // AR FSM, round-robin pointer, outstanding counters, routing error flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         lock_idx_q  <= '0;
         route_err_o <= 1'b0;
         for (int p = 0; p < int'(NoSlvPerGroup); p++) cnt_q[p] <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ar_valid && !mst_ar_ready_i) begin
                  state_q    <= ST_LOCKED;
                  lock_idx_q <= arb_idx;
               end
            end
            ST_LOCKED: begin
               if (mst_ar_ready_i) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase

         if (ar_hs) rr_ptr_q <= IdxW'((int'(grant) + 1) % int'(NoSlvPerGroup));

         // Simultaneous issue and completion on one port cancel out; decrement saturates
         for (int p = 0; p < int'(NoSlvPerGroup); p++) begin
            if (ar_hs && (grant == IdxW'(p)) && !(r_last_hs && (r_idx == IdxW'(p)))) begin
               cnt_q[p] <= cnt_q[p] + CntW'(1);
            end else if (r_last_hs && (r_idx == IdxW'(p)) && !(ar_hs && (grant == IdxW'(p)))) begin
               if (cnt_q[p] != '0) cnt_q[p] <= cnt_q[p] - CntW'(1);
            end
         end

         if (mst_r_valid_i && !r_in_range) route_err_o <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   // A locked slave must keep its request up until the handshake
   a_ar_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == ST_LOCKED) |-> slv_ar_valid_i[lock_idx_q]);
   // A last beat must never arrive for a port with nothing outstanding
   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (r_last_hs && !(ar_hs && (grant == r_idx))) |-> (cnt_q[r_idx] != '0));
`endif

endmodule
